axil_rr_arbiter: RTL and testbench
==================================

Name: axil_rr_arbiter

Overview:
- Shares one AXI-Lite slave port (UART register block at 0x4000_0000) between NM AXI-Lite masters, e.g. CPU data port and the boot/hello micro-sequencer.
- Read and write paths are arbitrated independently, each round-robin.
- A grant is held from address acceptance until the matching response handshake, so one outstanding read and one outstanding write exist at most.

Parameters:
AW, 32, address width
DW, 32, data width
NM, 2, number of masters (2..8)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
S_AWADDR  in  NM*AW  per-master write address, master i at bits [i*AW +: AW]
S_AWVALID  in  NM  per-master AW valid
S_AWREADY  out  NM  per-master AW ready
S_WDATA  in  NM*DW  per-master write data
S_WSTRB  in  NM*DW/8  per-master write strobes
S_WVALID  in  NM  per-master W valid
S_WREADY  out  NM  per-master W ready
S_BRESP  out  NM*2  per-master write response
S_BVALID  out  NM  per-master B valid
S_BREADY  in  NM  per-master B ready
S_ARADDR  in  NM*AW  per-master read address
S_ARVALID  in  NM  per-master AR valid
S_ARREADY  out  NM  per-master AR ready
S_RDATA  out  NM*DW  per-master read data
S_RRESP  out  NM*2  per-master read response
S_RVALID  out  NM  per-master R valid
S_RREADY  in  NM  per-master R ready
M_AW*/M_W*/M_B*/M_AR*/M_R*  mixed  AW/DW/DW/8/2  single downstream AXI-Lite master port, same signal set as one S_ slice with directions reversed
wr_gnt  out  NM  one-hot current write owner, 0 when idle
rd_gnt  out  NM  one-hot current read owner, 0 when idle

Behaviour:
- Clock and reset: ACLK, ARESETn asynchronous active-low.
- Reset state: all FSMs IDLE, grants 0, all VALID/READY outputs 0. Round-robin pointers set so master 0 has highest priority first.
- Write request from master i = S_AWVALID[i] | S_WVALID[i].
- Write FSM, IDLE: if any request, register the winner into wr_gnt and go to WADDR. No handshake occurs in the IDLE cycle, so minimum one cycle of arbitration latency.
- Write FSM, WADDR: forward the granted master's AW and W combinationally to M_. Track aw_done and w_done flags; AW and W may complete in either order or in the same cycle. After a channel completes, its S_ ready and M_ valid are held 0. When both are done, go to WRESP.
- Write FSM, WRESP: route M_BVALID/M_BRESP to the owner and S_BREADY[owner] to M_BREADY. On the B handshake, clear wr_gnt, update the pointer to owner+1 mod NM, go to IDLE.
- Read FSM is identical: IDLE -> RADDR (AR forwarded, done on M_ARVALID&M_ARREADY) -> RRESP (R routed, done on R handshake) -> IDLE, with its own pointer.
- Round robin: the winner is the first requester scanning from the pointer upward, wrapping at NM-1 -> 0. Simultaneous requests are resolved by this scan only.
- Non-granted masters: READY outputs 0, BVALID/RVALID 0, BRESP/RRESP/RDATA 0. Their requests stay pending, with no timeout.
- M_ outputs with no owner: valids 0, address/data/strobe 0, BREADY/RREADY 0.
- Read and write proceed concurrently, including to different or the same master. No ordering is enforced between them.
- A pointer advances only on response completion, never at grant time.
- Mid-transaction ARESETn: immediate return to reset state; the downstream transaction is abandoned, and the slave is reset by the same ARESETn.
- Masters deasserting VALID before the handshake is an AXI violation and unsupported. The arbiter does not re-arbitrate once granted.
- Pass-through paths are combinational from the registered grant. The only registers are the FSMs, grants, done flags and pointers. Total latency added is one cycle per transaction.

Test Plan:
- Single master 0 writes 0x48 to 0x4000_0000, slave ready always: wr_gnt=01 one cycle after AWVALID. M_AWADDR=0x4000_0000, M_WDATA=0x48, M_WSTRB=0x1. BRESP=0 returned to master 0 only. wr_gnt returns to 00 after B.
- Masters 0 and 1 both issue AR to 0x4000_0008 in the same cycle after reset: master 0 is served first, then master 1. RDATA 0x1 and 0x0 are each delivered only to their own requester.
- Both masters continuously request writes for 4 transactions: grant order 0,1,0,1, and each B is routed to the correct owner.
- Master 1 presents WVALID 3 cycles before AWVALID, slave AWREADY delayed 2 cycles: a single downstream write with correct data, then B to master 1. No duplicate M_AWVALID after acceptance.
- Master 0 write and master 1 read issued together: both downstream transactions overlap. wr_gnt=01 and rd_gnt=10 are simultaneous, and responses are correctly routed.
- ARESETn pulsed while in WRESP with BVALID low: all outputs 0 and grants 00 immediately. The next request from master 1 alone is granted, and master 0 keeps priority on a tie.

Source files
------------

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: shares one downstream AXI-Lite slave port between NM
// upstream masters. Read and write paths each have their own round-robin
// arbiter. A grant is held from address acceptance to response handshake,
// so at most one write and one read are outstanding downstream.
module axil_rr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NM = 2
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  // upstream (per-master) write channels
  input  logic [NM*AW-1:0]     S_AWADDR,
  input  logic [NM-1:0]        S_AWVALID,
  output logic [NM-1:0]        S_AWREADY,
  input  logic [NM*DW-1:0]     S_WDATA,
  input  logic [NM*DW/8-1:0]   S_WSTRB,
  input  logic [NM-1:0]        S_WVALID,
  output logic [NM-1:0]        S_WREADY,
  output logic [NM*2-1:0]      S_BRESP,
  output logic [NM-1:0]        S_BVALID,
  input  logic [NM-1:0]        S_BREADY,
  // upstream (per-master) read channels
  input  logic [NM*AW-1:0]     S_ARADDR,
  input  logic [NM-1:0]        S_ARVALID,
  output logic [NM-1:0]        S_ARREADY,
  output logic [NM*DW-1:0]     S_RDATA,
  output logic [NM*2-1:0]      S_RRESP,
  output logic [NM-1:0]        S_RVALID,
  input  logic [NM-1:0]        S_RREADY,
  // downstream port
  output logic [AW-1:0]        M_AWADDR,
  output logic                 M_AWVALID,
  input  logic                 M_AWREADY,
  output logic [DW-1:0]        M_WDATA,
  output logic [DW/8-1:0]      M_WSTRB,
  output logic                 M_WVALID,
  input  logic                 M_WREADY,
  input  logic [1:0]           M_BRESP,
  input  logic                 M_BVALID,
  output logic                 M_BREADY,
  output logic [AW-1:0]        M_ARADDR,
  output logic                 M_ARVALID,
  input  logic                 M_ARREADY,
  input  logic [DW-1:0]        M_RDATA,
  input  logic [1:0]           M_RRESP,
  input  logic                 M_RVALID,
  output logic                 M_RREADY,
  // current owners
  output logic [NM-1:0]        wr_gnt,
  output logic [NM-1:0]        rd_gnt
);

  localparam int IW = $clog2(NM);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_RESP = 2'd2} rd_state_t;

  // First requester at or above ptr, wrapping NM-1 -> 0. Scanning downward
  // lets the nearest requester overwrite any farther one.
  function automatic logic [IW-1:0] rr_pick(input logic [NM-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    int j;
    pick = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NM) j = j - NM;
      if (req[j]) pick = IW'(j);
    end
    return pick;
  endfunction

  // write path state
  wr_state_t      r_wr_state;
  logic [NM-1:0]  r_wr_gnt;
  logic [IW-1:0]  r_wr_idx;
  logic [IW-1:0]  r_wr_ptr;
  logic           r_aw_done;
  logic           r_w_done;

  // read path state
  rd_state_t      r_rd_state;
  logic [NM-1:0]  r_rd_gnt;
  logic [IW-1:0]  r_rd_idx;
  logic [IW-1:0]  r_rd_ptr;

  logic [NM-1:0]  w_wr_req;
  logic [IW-1:0]  w_wr_pick;
  logic [IW-1:0]  w_rd_pick;
  logic           w_aw_phase, w_w_phase, w_b_phase;
  logic           w_aw_fire, w_w_fire, w_b_fire;
  logic           w_ar_phase, w_r_phase;
  logic           w_ar_fire, w_r_fire;

  assign w_wr_req  = S_AWVALID | S_WVALID;
  assign w_wr_pick = rr_pick(w_wr_req, r_wr_ptr);
  assign w_rd_pick = rr_pick(S_ARVALID, r_rd_ptr);

  // a channel stops being forwarded as soon as it has completed
  assign w_aw_phase = (r_wr_state == WR_ADDR) && !r_aw_done;
  assign w_w_phase  = (r_wr_state == WR_ADDR) && !r_w_done;
  assign w_b_phase  = (r_wr_state == WR_RESP);
  assign w_ar_phase = (r_rd_state == RD_ADDR);
  assign w_r_phase  = (r_rd_state == RD_RESP);

  // downstream side, muxed from the registered owner index
  assign M_AWVALID = w_aw_phase && S_AWVALID[r_wr_idx];
  assign M_AWADDR  = w_aw_phase ? S_AWADDR[int'(r_wr_idx)*AW +: AW] : '0;
  assign M_WVALID  = w_w_phase && S_WVALID[r_wr_idx];
  assign M_WDATA   = w_w_phase ? S_WDATA[int'(r_wr_idx)*DW +: DW] : '0;
  assign M_WSTRB   = w_w_phase ? S_WSTRB[int'(r_wr_idx)*SW +: SW] : '0;
  assign M_BREADY  = w_b_phase && S_BREADY[r_wr_idx];
  assign M_ARVALID = w_ar_phase && S_ARVALID[r_rd_idx];
  assign M_ARADDR  = w_ar_phase ? S_ARADDR[int'(r_rd_idx)*AW +: AW] : '0;
  assign M_RREADY  = w_r_phase && S_RREADY[r_rd_idx];

  assign w_aw_fire = M_AWVALID && M_AWREADY;
  assign w_w_fire  = M_WVALID && M_WREADY;
  assign w_b_fire  = M_BVALID && M_BREADY;
  assign w_ar_fire = M_ARVALID && M_ARREADY;
  assign w_r_fire  = M_RVALID && M_RREADY;

  // upstream side: only the owner ever sees ready/valid/response data
  for (genvar gi = 0; gi < NM; gi++) begin : g_slv
    assign S_AWREADY[gi]        = r_wr_gnt[gi] && w_aw_phase && M_AWREADY;
    assign S_WREADY[gi]         = r_wr_gnt[gi] && w_w_phase && M_WREADY;
    assign S_BVALID[gi]         = r_wr_gnt[gi] && w_b_phase && M_BVALID;
    assign S_BRESP[gi*2 +: 2]   = (r_wr_gnt[gi] && w_b_phase) ? M_BRESP : 2'b00;
    assign S_ARREADY[gi]        = r_rd_gnt[gi] && w_ar_phase && M_ARREADY;
    assign S_RVALID[gi]         = r_rd_gnt[gi] && w_r_phase && M_RVALID;
    assign S_RRESP[gi*2 +: 2]   = (r_rd_gnt[gi] && w_r_phase) ? M_RRESP : 2'b00;
    assign S_RDATA[gi*DW +: DW] = (r_rd_gnt[gi] && w_r_phase) ? M_RDATA : '0;
  end

  assign wr_gnt = r_wr_gnt;
  assign rd_gnt = r_rd_gnt;

  // write FSM: arbitrate, collect AW and W in any order, then wait for B
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_state <= WR_IDLE;
      r_wr_gnt   <= '0;
      r_wr_idx   <= '0;
      r_wr_ptr   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (|w_wr_req) begin
            r_wr_gnt   <= NM'(1) << w_wr_pick;
            r_wr_idx   <= w_wr_pick;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= WR_RESP;
          end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (w_b_fire) begin
            r_wr_gnt   <= '0;
            r_wr_ptr   <= (r_wr_idx == IW'(NM - 1)) ? '0 : r_wr_idx + 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // read FSM: arbitrate, forward AR, then wait for R
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rd_state <= RD_IDLE;
      r_rd_gnt   <= '0;
      r_rd_idx   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (|S_ARVALID) begin
            r_rd_gnt   <= NM'(1) << w_rd_pick;
            r_rd_idx   <= w_rd_pick;
            r_rd_state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (w_ar_fire) r_rd_state <= RD_RESP;
        end
        RD_RESP: begin
          if (w_r_fire) begin
            r_rd_gnt   <= '0;
            r_rd_ptr   <= (r_rd_idx == IW'(NM - 1)) ? '0 : r_rd_idx + 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: random masters and a random-latency slave around the
// arbiter, checked cycle by cycle against a transaction-level reference
// (owner, round-robin pointer, which channels of the current transaction
// have already been accepted).
module tb_axil_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 3;
  localparam int SW = DW / 8;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [NM*AW-1:0] S_AWADDR;
  logic [NM-1:0]    S_AWVALID, S_AWREADY;
  logic [NM*DW-1:0] S_WDATA;
  logic [NM*SW-1:0] S_WSTRB;
  logic [NM-1:0]    S_WVALID, S_WREADY;
  logic [NM*2-1:0]  S_BRESP;
  logic [NM-1:0]    S_BVALID, S_BREADY;
  logic [NM*AW-1:0] S_ARADDR;
  logic [NM-1:0]    S_ARVALID, S_ARREADY;
  logic [NM*DW-1:0] S_RDATA;
  logic [NM*2-1:0]  S_RRESP;
  logic [NM-1:0]    S_RVALID, S_RREADY;
  logic [AW-1:0]    M_AWADDR;
  logic             M_AWVALID, M_AWREADY;
  logic [DW-1:0]    M_WDATA;
  logic [SW-1:0]    M_WSTRB;
  logic             M_WVALID, M_WREADY;
  logic [1:0]       M_BRESP;
  logic             M_BVALID, M_BREADY;
  logic [AW-1:0]    M_ARADDR;
  logic             M_ARVALID, M_ARREADY;
  logic [DW-1:0]    M_RDATA;
  logic [1:0]       M_RRESP;
  logic             M_RVALID, M_RREADY;
  logic [NM-1:0]    wr_gnt, rd_gnt;

  always #5 ACLK = ~ACLK;

  axil_rr_arbiter #(.AW(AW), .DW(DW), .NM(NM)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // upstream masters
  int               mw_st[NM];     // 0 idle, 1 sending AW/W, 2 awaiting B
  logic [AW-1:0]    mw_addr[NM];
  logic [DW-1:0]    mw_data[NM];
  logic [SW-1:0]    mw_strb[NM];
  int               mw_awdly[NM], mw_wdly[NM];
  bit               mw_awdone[NM], mw_wdone[NM];
  int               mr_st[NM];     // 0 idle, 1 sending AR, 2 awaiting R
  logic [AW-1:0]    mr_addr[NM];
  int               mr_dly[NM];
  // reference arbiter: owner (-1 none), next-priority pointer, accepted channels
  int wo, wptr, ro, rptr;
  bit aw_sent, w_sent, ar_sent;
  // downstream slave
  bit sb_pend, sb_valid, hold_b;
  int sb_dly;
  logic [1:0] sb_resp;
  bit sr_pend, sr_valid;
  int sr_dly;
  logic [DW-1:0] sr_data;
  logic [1:0] sr_resp;

  function automatic int rr_winner(input logic [NM-1:0] req, input int ptr);
    for (int k = 0; k < NM; k++) begin
      if (req[(ptr + k) % NM]) return (ptr + k) % NM;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = (wo >= 0) || (ro >= 0);
    for (int m = 0; m < NM; m++) if (mw_st[m] != 0 || mr_st[m] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      mw_st[m] = 0; mr_st[m] = 0; mw_awdone[m] = 0; mw_wdone[m] = 0;
      mw_awdly[m] = 0; mw_wdly[m] = 0; mr_dly[m] = 0;
    end
    wo = -1; ro = -1; wptr = 0; rptr = 0;
    aw_sent = 0; w_sent = 0; ar_sent = 0;
    sb_pend = 0; sb_valid = 0; hold_b = 0; sb_dly = 0; sb_resp = 2'b00;
    sr_pend = 0; sr_valid = 0; sr_dly = 0; sr_data = '0; sr_resp = 2'b00;
  endtask

  task automatic zero_inputs();
    S_AWADDR = '0; S_AWVALID = '0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = '0; S_BREADY = '0;
    S_ARADDR = '0; S_ARVALID = '0; S_RREADY = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BRESP = 2'b00; M_BVALID = 0;
    M_ARREADY = 0; M_RDATA = '0; M_RRESP = 2'b00; M_RVALID = 0;
  endtask

  task automatic start_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int awd, input int wd);
    mw_st[m] = 1; mw_addr[m] = a; mw_data[m] = d; mw_strb[m] = s;
    mw_awdly[m] = awd; mw_wdly[m] = wd; mw_awdone[m] = 0; mw_wdone[m] = 0;
  endtask

  task automatic start_read(input int m, input logic [AW-1:0] a, input int dly);
    mr_st[m] = 1; mr_addr[m] = a; mr_dly[m] = dly;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 32'h4000_0000 | (AW'($urandom_range(0, 15)) << 2);
  endfunction

  // one clock: drive after the falling edge, check the settled outputs,
  // then advance the reference to the state after the next rising edge
  task automatic step(input bit allow_new);
    logic [NM-1:0] own, mask;
    logic [1:0]    oth_resp;
    logic [DW-1:0] oth_data;
    int wwin, rwin;
    bit awf, wf, bf, arf, rf;
    @(negedge ACLK);
    if (allow_new) begin
      for (int m = 0; m < NM; m++) begin
        if (mw_st[m] == 0 && $urandom_range(0, 3) == 0)
          start_write(m, rand_addr(), $urandom, SW'($urandom_range(1, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        if (mr_st[m] == 0 && $urandom_range(0, 3) == 0)
          start_read(m, rand_addr(), $urandom_range(0, 2));
      end
    end
    for (int m = 0; m < NM; m++) begin
      S_AWVALID[m] = (mw_st[m] == 1) && !mw_awdone[m] && (mw_awdly[m] == 0);
      S_WVALID[m]  = (mw_st[m] == 1) && !mw_wdone[m] && (mw_wdly[m] == 0);
      S_AWADDR[m*AW +: AW] = mw_addr[m];
      S_WDATA[m*DW +: DW]  = mw_data[m];
      S_WSTRB[m*SW +: SW]  = mw_strb[m];
      S_BREADY[m]  = (mw_st[m] == 2) && ($urandom_range(0, 2) != 0);
      S_ARVALID[m] = (mr_st[m] == 1) && (mr_dly[m] == 0);
      S_ARADDR[m*AW +: AW] = mr_addr[m];
      S_RREADY[m]  = (mr_st[m] == 2) && ($urandom_range(0, 2) != 0);
    end
    if (sb_pend && !hold_b) begin
      if (sb_dly == 0) begin sb_valid = 1; sb_pend = 0; sb_resp = 2'($urandom_range(0, 3)); end
      else sb_dly--;
    end
    if (sr_pend) begin
      if (sr_dly == 0) begin sr_valid = 1; sr_pend = 0; sr_data = $urandom; sr_resp = 2'($urandom_range(0, 3)); end
      else sr_dly--;
    end
    M_AWREADY = 1'($urandom_range(0, 1));
    M_WREADY  = 1'($urandom_range(0, 1));
    M_ARREADY = 1'($urandom_range(0, 1));
    M_BVALID = sb_valid; M_BRESP = sb_resp;
    M_RVALID = sr_valid; M_RDATA = sr_data; M_RRESP = sr_resp;
    #1;
    awf = 0; wf = 0; bf = 0; arf = 0; rf = 0; wwin = -1; rwin = -1;

    // ---- write path ----
    check_eq("wr_gnt", 64'(wr_gnt), (wo < 0) ? 64'd0 : (64'd1 << wo));
    if (wo < 0) begin
      check_eq("wr_idle_s", 64'({S_AWREADY, S_WREADY, S_BVALID, S_BRESP}), 64'd0);
      check_eq("wr_idle_m", 64'({M_AWVALID, M_WVALID, M_BREADY, M_WSTRB}), 64'd0);
      check_eq("wr_idle_mdat", {M_AWADDR, M_WDATA}, 64'd0);
      if ((S_AWVALID | S_WVALID) != '0) wwin = rr_winner(S_AWVALID | S_WVALID, wptr);
    end else begin
      own = '0; own[wo] = 1'b1; mask = ~own;
      oth_resp = '0;
      for (int j = 0; j < NM; j++) if (j != wo) oth_resp |= S_BRESP[j*2 +: 2];
      check_eq("wr_others", 64'({S_AWREADY & mask, S_WREADY & mask, S_BVALID & mask, oth_resp}), 64'd0);
      if (!aw_sent) begin
        check_eq("m_awvalid", 64'(M_AWVALID), 64'(S_AWVALID[wo]));
        check_eq("s_awready", 64'(S_AWREADY[wo]), 64'(M_AWREADY));
        if (S_AWVALID[wo]) check_eq("m_awaddr", 64'(M_AWADDR), 64'(mw_addr[wo]));
        awf = S_AWVALID[wo] && M_AWREADY;
      end else check_eq("aw_held_off", 64'({M_AWVALID, S_AWREADY[wo]}), 64'd0);
      if (!w_sent) begin
        check_eq("m_wvalid", 64'(M_WVALID), 64'(S_WVALID[wo]));
        check_eq("s_wready", 64'(S_WREADY[wo]), 64'(M_WREADY));
        if (S_WVALID[wo]) check_eq("m_wdata_strb", {28'd0, M_WSTRB, M_WDATA}, {28'd0, mw_strb[wo], mw_data[wo]});
        wf = S_WVALID[wo] && M_WREADY;
      end else check_eq("w_held_off", 64'({M_WVALID, S_WREADY[wo]}), 64'd0);
      if (aw_sent && w_sent) begin
        check_eq("s_bvalid", 64'(S_BVALID[wo]), 64'(M_BVALID));
        check_eq("m_bready", 64'(M_BREADY), 64'(S_BREADY[wo]));
        if (M_BVALID) check_eq("s_bresp", 64'(S_BRESP[wo*2 +: 2]), 64'(sb_resp));
        bf = M_BVALID && S_BREADY[wo];
      end else check_eq("b_early", 64'({S_BVALID[wo], M_BREADY}), 64'd0);
    end

    // ---- read path ----
    check_eq("rd_gnt", 64'(rd_gnt), (ro < 0) ? 64'd0 : (64'd1 << ro));
    if (ro < 0) begin
      check_eq("rd_idle_s", 64'({S_ARREADY, S_RVALID, S_RRESP, |S_RDATA}), 64'd0);
      check_eq("rd_idle_m", 64'({M_ARVALID, M_RREADY, M_ARADDR}), 64'd0);
      if (S_ARVALID != '0) rwin = rr_winner(S_ARVALID, rptr);
    end else begin
      own = '0; own[ro] = 1'b1; mask = ~own;
      oth_resp = '0; oth_data = '0;
      for (int j = 0; j < NM; j++) if (j != ro) begin
        oth_resp |= S_RRESP[j*2 +: 2];
        oth_data |= S_RDATA[j*DW +: DW];
      end
      check_eq("rd_others", 64'({S_ARREADY & mask, S_RVALID & mask, oth_resp, |oth_data}), 64'd0);
      if (!ar_sent) begin
        check_eq("m_arvalid", 64'(M_ARVALID), 64'(S_ARVALID[ro]));
        check_eq("s_arready", 64'(S_ARREADY[ro]), 64'(M_ARREADY));
        if (S_ARVALID[ro]) check_eq("m_araddr", 64'(M_ARADDR), 64'(mr_addr[ro]));
        check_eq("r_early", 64'({S_RVALID[ro], M_RREADY}), 64'd0);
        arf = S_ARVALID[ro] && M_ARREADY;
      end else begin
        check_eq("ar_held_off", 64'({M_ARVALID, S_ARREADY[ro]}), 64'd0);
        check_eq("s_rvalid", 64'(S_RVALID[ro]), 64'(M_RVALID));
        check_eq("m_rready", 64'(M_RREADY), 64'(S_RREADY[ro]));
        if (M_RVALID) check_eq("s_rdata_resp", {30'd0, S_RRESP[ro*2 +: 2], S_RDATA[ro*DW +: DW]},
                               {30'd0, sr_resp, sr_data});
        rf = M_RVALID && S_RREADY[ro];
      end
    end

    // ---- masters observe their own handshakes ----
    for (int m = 0; m < NM; m++) begin
      if (mw_st[m] == 2 && S_BVALID[m] && S_BREADY[m]) begin
        $display("[TB] WR m%0d addr=%h data=%h strb=%h bresp=%0d", m, mw_addr[m], mw_data[m],
                 mw_strb[m], S_BRESP[m*2 +: 2]);
        mw_st[m] = 0;
      end
      if (mw_st[m] == 1) begin
        if (S_AWVALID[m] && S_AWREADY[m]) mw_awdone[m] = 1;
        if (S_WVALID[m] && S_WREADY[m]) mw_wdone[m] = 1;
        if (mw_awdly[m] > 0) mw_awdly[m]--;
        if (mw_wdly[m] > 0) mw_wdly[m]--;
        if (mw_awdone[m] && mw_wdone[m]) mw_st[m] = 2;
      end
      if (mr_st[m] == 2 && S_RVALID[m] && S_RREADY[m]) begin
        $display("[TB] RD m%0d addr=%h rdata=%h rresp=%0d", m, mr_addr[m], S_RDATA[m*DW +: DW],
                 S_RRESP[m*2 +: 2]);
        mr_st[m] = 0;
      end
      if (mr_st[m] == 1) begin
        if (S_ARVALID[m] && S_ARREADY[m]) mr_st[m] = 2;
        else if (mr_dly[m] > 0) mr_dly[m]--;
      end
    end

    // ---- reference advances ----
    if (awf) aw_sent = 1;
    if (wf) w_sent = 1;
    if ((awf || wf) && aw_sent && w_sent) begin sb_pend = 1; sb_dly = $urandom_range(0, 3); end
    if (bf) begin wptr = (wo + 1) % NM; wo = -1; aw_sent = 0; w_sent = 0; sb_valid = 0; end
    if (wwin >= 0) begin wo = wwin; aw_sent = 0; w_sent = 0; end
    if (arf) begin ar_sent = 1; sr_pend = 1; sr_dly = $urandom_range(0, 3); end
    if (rf) begin rptr = (ro + 1) % NM; ro = -1; ar_sent = 0; sr_valid = 0; end
    if (rwin >= 0) begin ro = rwin; ar_sent = 0; end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 400 && busy(); c++) step(1'b0);
    check_eq(tag, 64'(busy()), 64'd0);
  endtask

  initial begin
    int  cyc;
    ARESETn = 1'b0;
    zero_inputs();
    model_reset();
    // requests during reset must not produce any grant or handshake
    S_AWVALID = '1; S_WVALID = '1; S_ARVALID = '1;
    M_BVALID = 1; M_RVALID = 1; M_AWREADY = 1; M_WREADY = 1; M_ARREADY = 1;
    repeat (3) @(negedge ACLK);
    #1;
    check_eq("rst_gnt", 64'({wr_gnt, rd_gnt}), 64'd0);
    check_eq("rst_s", 64'({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID}), 64'd0);
    check_eq("rst_m", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}), 64'd0);
    zero_inputs();
    @(negedge ACLK);
    ARESETn = 1'b1;

    // master 0 writes 0x48 to the UART base: one idle arbitration cycle first
    start_write(0, 32'h4000_0000, 32'h48, 4'h1, 0, 0);
    step(1'b0);
    check_eq("first_gnt_idle", 64'(wr_gnt), 64'd0);
    step(1'b0);
    check_eq("first_gnt", 64'(wr_gnt), 64'b001);
    drain("drain_first");

    repeat (4000) step(1'b1);
    drain("drain_random");

    // asynchronous reset while a write waits for B
    hold_b = 1;
    start_write(0, 32'h4000_0004, 32'h55, 4'hF, 0, 0);
    cyc = 0;
    while (!(wo == 0 && aw_sent && w_sent) && cyc < 50) begin step(1'b0); cyc++; end
    check_eq("reach_wresp", 64'(wo == 0 && aw_sent && w_sent), 64'd1);
    #6;
    check_eq("pre_rst_gnt", 64'(wr_gnt), 64'b001);
    ARESETn = 1'b0;
    #1;
    check_eq("arst_gnt", 64'({wr_gnt, rd_gnt}), 64'd0);
    check_eq("arst_out", 64'({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID,
                              M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}), 64'd0);
    zero_inputs();
    model_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // lone writer is granted; simultaneous readers resolve to master 0
    start_write(1, 32'h4000_0008, 32'h1234, 4'h3, 0, 0);
    start_read(0, 32'h4000_0008, 0);
    start_read(1, 32'h4000_0008, 0);
    step(1'b0);
    step(1'b0);
    check_eq("solo_wr_gnt", 64'(wr_gnt), 64'b010);
    check_eq("tie_rd_gnt", 64'(rd_gnt), 64'b001);
    drain("drain_after_rst");

    repeat (800) step(1'b1);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
